multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
- Main control state machine of the multicycle MIPS datapath; the producer of the 3-bit ALUOp consumed by the ALU control decoder.
- Sequences fetch, decode, execute, memory and writeback per instruction, drives all datapath enables and muxes, and waits for memory latency.
- Halts on a BREAK funct.

Parameters:
- MEM_WAIT, 1, extra wait cycles per memory read (legal range 1..15); FETCH and MEM_READ each last MEM_WAIT+1 cycles.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- Opcode  in  6  instruction register bits [31:26]
- Funct  in  6  instruction register bits [5:0]
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  conditional PC load (branch)
- BranchNe  out  1  1 = bne, so PC loads when Zero=0; 0 = beq
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register load
- RegDst  out  1  0 = rt, 1 = rd
- MemToReg  out  1  0 = ALUOut, 1 = MDR
- RegWrite  out  1  register file write
- ALUSrcA  out  1  0 = PC, 1 = A
- ALUSrcB  out  2  00 = B, 01 = 4, 10 = signext, 11 = signext<<2
- ALUOp  out  3  000 = add, 001 = sub, 010 = use funct
- PCSource  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
- BadOpcode  out  1  one-cycle pulse on an unsupported opcode
- Halted  out  1  high while in HALT
- State  out  4  current state encoding, for debug
- InstrCount  out  32  count of instructions fetched

Behaviour:
- Moore outputs are decoded from State only. Any output not listed for a state is 0.
- Async reset (reset=0) forces State=RESET(0), wait counter=0, InstrCount=0, and all outputs 0.
- RESET lasts exactly one cycle after reset deasserts, then goes to FETCH.
- State encodings:
  - RESET=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6
  - R_EXEC=7, R_WB=8, BRANCH=9, JUMP=10, ADDI_EXEC=11, ADDI_WB=12, HALT=13
- Wait counter (4 bits):
  - Cleared on entry to FETCH and MEM_READ; increments each cycle in those states.
  - The state exits when counter==MEM_WAIT.
- FETCH:
  - IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=000, PCSource=00.
  - IRWrite=1, PCWrite=1 and InstrCount+1 occur only on the final cycle; next state DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=000. Next state by Opcode:
  - 0x00 with Funct=0x0D → HALT; other 0x00 → R_EXEC
  - 0x23 or 0x2B → MEM_ADDR
  - 0x04 or 0x05 → BRANCH
  - 0x02 → JUMP
  - 0x08 → ADDI_EXEC
  - anything else → FETCH, with BadOpcode=1 for that DECODE cycle
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=000. Next state MEM_READ for 0x23, MEM_WRITE for 0x2B.
- MEM_READ: IorD=1 for all MEM_WAIT+1 cycles, then MEM_WB.
- MEM_WB: RegDst=0, MemToReg=1, RegWrite=1 → FETCH.
- MEM_WRITE: IorD=1, MemWrite=1 for exactly one cycle → FETCH.
- R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=010 → R_WB.
- R_WB: RegDst=1, MemToReg=0, RegWrite=1 → FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCSource=01, PCWriteCond=1; BranchNe=1 iff Opcode=0x05. → FETCH.
- JUMP: PCSource=10, PCWrite=1 → FETCH.
- ADDI_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=000 → ADDI_WB.
- ADDI_WB: RegDst=0, MemToReg=0, RegWrite=1 → FETCH.
- HALT: Halted=1, all enables 0; absorbing state, left only by reset.
- Opcode and Funct are sampled only in DECODE and MEM_ADDR; the IR is stable outside FETCH.
- InstrCount wraps from 0xFFFFFFFF to 0 with no flag.
- Reset mid-operation (including mid MEM_READ or mid MEM_WRITE) takes effect immediately and asynchronously. No partial write enable may persist past the reset edge.
- No two of IRWrite, MemWrite, RegWrite are ever high in the same cycle.
- Cycle counts per instruction with MEM_WAIT=1:
  - R-type 5, lw 7, sw 5, beq/bne 4, j 4, addi 5, unsupported opcode 3.

Test Plan:
- Reset held low 3 cycles then released, MEM_WAIT=1 → State=0 for one cycle, then 1; outputs all 0 during reset; IRWrite and PCWrite high only on the 2nd FETCH cycle; InstrCount=1 afterwards.
- Opcode=0x23 with MEM_WAIT=2 → state trace 1,1,1,2,3,4,4,4,5,1. IorD=1 for all three MEM_READ cycles; RegWrite=1 with MemToReg=1 only in state 5; 9 cycles total.
- Opcode=0x00, Funct=0x20, then Funct=0x0D → first: R_EXEC with ALUOp=010, then R_WB with RegDst=1 and RegWrite=1. Second: DECODE→HALT, Halted=1 held for 20 cycles, InstrCount frozen.
- Opcode=0x05 → BRANCH with ALUOp=001, PCWriteCond=1, BranchNe=1, PCSource=01. Repeat with 0x04 → BranchNe=0.
- Opcode=0x3F → BadOpcode high exactly one cycle in DECODE, then FETCH; no write enable asserted during that instruction.
- reset pulled low on the 2nd cycle of MEM_READ (MEM_WAIT=3) → State=0 and IorD=0 within the same cycle, before any clock edge; after release, FETCH begins and InstrCount restarts at 0.

Source files
------------

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle MIPS main FSM (master) and its datapath (slave).
// Opcode/Funct come from the instruction register; everything else is FSM-driven.
interface multicycle_control_fsm_if;
  logic [5:0]  Opcode;
  logic [5:0]  Funct;
  logic        PCWrite;
  logic        PCWriteCond;
  logic        BranchNe;
  logic        IorD;
  logic        MemWrite;
  logic        IRWrite;
  logic        RegDst;
  logic        MemToReg;
  logic        RegWrite;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [2:0]  ALUOp;
  logic [1:0]  PCSource;
  logic        BadOpcode;
  logic        Halted;
  logic [3:0]  State;
  logic [31:0] InstrCount;

  modport master (
    input  Opcode, Funct,
    output PCWrite, PCWriteCond, BranchNe, IorD, MemWrite, IRWrite, RegDst,
           MemToReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, BadOpcode,
           Halted, State, InstrCount
  );

  modport slave (
    output Opcode, Funct,
    input  PCWrite, PCWriteCond, BranchNe, IorD, MemWrite, IRWrite, RegDst,
           MemToReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, BadOpcode,
           Halted, State, InstrCount
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multicycle MIPS datapath: fetch/decode/execute/memory/writeback
// sequencing with a programmable memory wait, registered Moore outputs and a halt on BREAK.
module multicycle_control_fsm #(
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  multicycle_control_fsm_if.master bus
);

  typedef enum logic [3:0] {
    S_RESET     = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_ADDI_EXEC = 4'd11,
    S_ADDI_WB   = 4'd12,
    S_HALT      = 4'd13
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       ior_d;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       halted;
  } ctrl_t;

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

  state_t      state, state_nxt;
  logic [3:0]  wait_cnt, wait_cnt_nxt;
  logic [31:0] instr_count, instr_count_nxt;
  logic        bad_op;
  ctrl_t       ctrl, ctrl_nxt;

  // Outputs are registered by decoding the state being entered; "last" marks the final
  // cycle of a wait state, which is where FETCH loads IR and PC.
  function automatic ctrl_t decode(input state_t s, input logic last, input logic bne);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.alu_src_b = 2'b01;
        c.ir_write  = last;
        c.pc_write  = last;
      end
      S_DECODE:    c.alu_src_b = 2'b11;
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_MEM_READ:  c.ior_d = 1'b1;
      S_MEM_WB: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      S_MEM_WRITE: begin
        c.ior_d     = 1'b1;
        c.mem_write = 1'b1;
      end
      S_R_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 3'b010;
      end
      S_R_WB: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 3'b001;
        c.pc_source     = 2'b01;
        c.pc_write_cond = 1'b1;
        c.branch_ne     = bne;
      end
      S_JUMP: begin
        c.pc_source = 2'b10;
        c.pc_write  = 1'b1;
      end
      S_ADDI_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_ADDI_WB:   c.reg_write = 1'b1;
      S_HALT:      c.halted = 1'b1;
      default:     c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_nxt       = state;
    wait_cnt_nxt    = wait_cnt;
    instr_count_nxt = instr_count;
    bad_op          = 1'b0;
    case (state)
      S_RESET: state_nxt = S_FETCH;
      S_FETCH: begin
        if (wait_cnt == WAIT_LAST) begin
          state_nxt       = S_DECODE;
          instr_count_nxt = instr_count + 32'd1;
        end else begin
          wait_cnt_nxt = wait_cnt + 4'd1;
        end
      end
      S_DECODE: begin
        case (bus.Opcode)
          6'h00:        state_nxt = (bus.Funct == 6'h0D) ? S_HALT : S_R_EXEC;
          6'h23, 6'h2B: state_nxt = S_MEM_ADDR;
          6'h04, 6'h05: state_nxt = S_BRANCH;
          6'h02:        state_nxt = S_JUMP;
          6'h08:        state_nxt = S_ADDI_EXEC;
          default: begin
            state_nxt = S_FETCH;
            bad_op    = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: state_nxt = (bus.Opcode == 6'h23) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ: begin
        if (wait_cnt == WAIT_LAST) state_nxt = S_MEM_WB;
        else                       wait_cnt_nxt = wait_cnt + 4'd1;
      end
      S_R_EXEC:    state_nxt = S_R_WB;
      S_ADDI_EXEC: state_nxt = S_ADDI_WB;
      S_MEM_WB, S_MEM_WRITE, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: state_nxt = S_FETCH;
      S_HALT:      state_nxt = S_HALT;
      default:     state_nxt = S_RESET;
    endcase
    if ((state_nxt == S_FETCH || state_nxt == S_MEM_READ) && state_nxt != state)
      wait_cnt_nxt = 4'd0;
  end

  assign ctrl_nxt = decode(state_nxt, wait_cnt_nxt == WAIT_LAST, bus.Opcode == 6'h05);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_RESET;
      wait_cnt    <= 4'd0;
      instr_count <= 32'd0;
      ctrl        <= '0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_cnt_nxt;
      instr_count <= instr_count_nxt;
      ctrl        <= ctrl_nxt;
    end
  end

  // BadOpcode must reflect the IR during DECODE itself, so it stays combinational.
  assign bus.BadOpcode   = bad_op;
  assign bus.PCWrite     = ctrl.pc_write;
  assign bus.PCWriteCond = ctrl.pc_write_cond;
  assign bus.BranchNe    = ctrl.branch_ne;
  assign bus.IorD        = ctrl.ior_d;
  assign bus.MemWrite    = ctrl.mem_write;
  assign bus.IRWrite     = ctrl.ir_write;
  assign bus.RegDst      = ctrl.reg_dst;
  assign bus.MemToReg    = ctrl.mem_to_reg;
  assign bus.RegWrite    = ctrl.reg_write;
  assign bus.ALUSrcA     = ctrl.alu_src_a;
  assign bus.ALUSrcB     = ctrl.alu_src_b;
  assign bus.ALUOp       = ctrl.alu_op;
  assign bus.PCSource    = ctrl.pc_source;
  assign bus.Halted      = ctrl.halted;
  assign bus.State       = state;
  assign bus.InstrCount  = instr_count;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: a per-cycle vector table at MEM_WAIT=1 plus
// hand-written sequences for halt, MEM_WAIT=2 load timing and reset during MEM_READ.
module tb_multicycle_control_fsm;

  logic clock = 1'b0;
  logic reset1 = 1'b0, reset2 = 1'b0, reset3 = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  multicycle_control_fsm_if bus1 ();
  multicycle_control_fsm_if bus2 ();
  multicycle_control_fsm_if bus3 ();

  multicycle_control_fsm #(.MEM_WAIT(1)) dut1 (.clock(clock), .reset(reset1), .bus(bus1));
  multicycle_control_fsm #(.MEM_WAIT(2)) dut2 (.clock(clock), .reset(reset2), .bus(bus2));
  multicycle_control_fsm #(.MEM_WAIT(3)) dut3 (.clock(clock), .reset(reset3), .bus(bus3));

  // {PCWrite,PCWriteCond,BranchNe,IorD,MemWrite,IRWrite,RegDst,MemToReg,RegWrite,ALUSrcA,
  //  ALUSrcB[1:0],ALUOp[2:0],PCSource[1:0],BadOpcode,Halted}
  logic [18:0] ctl1;
  assign ctl1 = {bus1.PCWrite, bus1.PCWriteCond, bus1.BranchNe, bus1.IorD, bus1.MemWrite,
                 bus1.IRWrite, bus1.RegDst, bus1.MemToReg, bus1.RegWrite, bus1.ALUSrcA,
                 bus1.ALUSrcB, bus1.ALUOp, bus1.PCSource, bus1.BadOpcode, bus1.Halted};

  localparam logic [18:0] E_ZERO     = 19'b0;
  localparam logic [18:0] E_FETCH    = {10'b0000000000, 2'b01, 3'b000, 2'b00, 2'b00};
  localparam logic [18:0] E_FETCH_L  = {10'b1000010000, 2'b01, 3'b000, 2'b00, 2'b00};
  localparam logic [18:0] E_DECODE   = {10'b0000000000, 2'b11, 3'b000, 2'b00, 2'b00};
  localparam logic [18:0] E_BAD      = {10'b0000000000, 2'b11, 3'b000, 2'b00, 2'b10};
  localparam logic [18:0] E_MEMADDR  = {10'b0000000001, 2'b10, 3'b000, 2'b00, 2'b00};
  localparam logic [18:0] E_MEMREAD  = {10'b0001000000, 2'b00, 3'b000, 2'b00, 2'b00};
  localparam logic [18:0] E_MEMWB    = {10'b0000000110, 2'b00, 3'b000, 2'b00, 2'b00};
  localparam logic [18:0] E_MEMWRITE = {10'b0001100000, 2'b00, 3'b000, 2'b00, 2'b00};
  localparam logic [18:0] E_REXEC    = {10'b0000000001, 2'b00, 3'b010, 2'b00, 2'b00};
  localparam logic [18:0] E_RWB      = {10'b0000001010, 2'b00, 3'b000, 2'b00, 2'b00};
  localparam logic [18:0] E_BEQ      = {10'b0100000001, 2'b00, 3'b001, 2'b01, 2'b00};
  localparam logic [18:0] E_BNE      = {10'b0110000001, 2'b00, 3'b001, 2'b01, 2'b00};
  localparam logic [18:0] E_JUMP     = {10'b1000000000, 2'b00, 3'b000, 2'b10, 2'b00};
  localparam logic [18:0] E_ADDIEX   = {10'b0000000001, 2'b10, 3'b000, 2'b00, 2'b00};
  localparam logic [18:0] E_ADDIWB   = {10'b0000000010, 2'b00, 3'b000, 2'b00, 2'b00};
  localparam logic [18:0] E_HALT     = {10'b0000000000, 2'b00, 3'b000, 2'b00, 2'b01};

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [3:0]  st;
    logic [18:0] ctl;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic row(input logic [5:0] op, input logic [5:0] funct, input logic [3:0] st,
                     input logic [18:0] ctl, input logic [31:0] cnt);
    vec_t v;
    v.op = op; v.funct = funct; v.st = st; v.ctl = ctl; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  task automatic fetch2(input logic [5:0] op, input logic [5:0] funct, input logic [31:0] cnt);
    row(op, funct, 4'd1, E_FETCH, cnt);
    row(op, funct, 4'd1, E_FETCH_L, cnt);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  logic [3:0] exp2 [11];

  initial begin
    row(6'h00, 6'h00, 4'd0, E_ZERO, 0);
    fetch2(6'h00, 6'h20, 0);
    row(6'h00, 6'h20, 4'd2,  E_DECODE,   1);
    row(6'h00, 6'h20, 4'd7,  E_REXEC,    1);
    row(6'h00, 6'h20, 4'd8,  E_RWB,      1);
    fetch2(6'h23, 6'h00, 1);
    row(6'h23, 6'h00, 4'd2,  E_DECODE,   2);
    row(6'h23, 6'h00, 4'd3,  E_MEMADDR,  2);
    row(6'h23, 6'h00, 4'd4,  E_MEMREAD,  2);
    row(6'h23, 6'h00, 4'd4,  E_MEMREAD,  2);
    row(6'h23, 6'h00, 4'd5,  E_MEMWB,    2);
    fetch2(6'h2B, 6'h00, 2);
    row(6'h2B, 6'h00, 4'd2,  E_DECODE,   3);
    row(6'h2B, 6'h00, 4'd3,  E_MEMADDR,  3);
    row(6'h2B, 6'h00, 4'd6,  E_MEMWRITE, 3);
    fetch2(6'h05, 6'h00, 3);
    row(6'h05, 6'h00, 4'd2,  E_DECODE,   4);
    row(6'h05, 6'h00, 4'd9,  E_BNE,      4);
    fetch2(6'h04, 6'h00, 4);
    row(6'h04, 6'h00, 4'd2,  E_DECODE,   5);
    row(6'h04, 6'h00, 4'd9,  E_BEQ,      5);
    fetch2(6'h02, 6'h00, 5);
    row(6'h02, 6'h00, 4'd2,  E_DECODE,   6);
    row(6'h02, 6'h00, 4'd10, E_JUMP,     6);
    fetch2(6'h08, 6'h00, 6);
    row(6'h08, 6'h00, 4'd2,  E_DECODE,   7);
    row(6'h08, 6'h00, 4'd11, E_ADDIEX,   7);
    row(6'h08, 6'h00, 4'd12, E_ADDIWB,   7);
    fetch2(6'h3F, 6'h00, 7);
    row(6'h3F, 6'h00, 4'd2,  E_BAD,      8);
    fetch2(6'h00, 6'h0D, 8);
    row(6'h00, 6'h0D, 4'd2,  E_DECODE,   9);
    row(6'h00, 6'h0D, 4'd13, E_HALT,     9);
    exp2 = '{4'd0, 4'd1, 4'd1, 4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd4, 4'd5, 4'd1};

    bus1.Opcode = 6'h00; bus1.Funct = 6'h00;
    bus2.Opcode = 6'h23; bus2.Funct = 6'h00;
    bus3.Opcode = 6'h23; bus3.Funct = 6'h00;

    // Reset held for three cycles: everything at zero.
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("rst%0d_state", i), 64'(bus1.State), 64'd0);
      check($sformatf("rst%0d_ctl", i), 64'(ctl1), 64'(E_ZERO));
      check($sformatf("rst%0d_count", i), 64'(bus1.InstrCount), 64'd0);
    end
    reset1 = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      bus1.Opcode = tbl[i].op;
      bus1.Funct  = tbl[i].funct;
      #4;
      check($sformatf("row%0d_state", i), 64'(bus1.State), 64'(tbl[i].st));
      check($sformatf("row%0d_ctl", i), 64'(ctl1), 64'(tbl[i].ctl));
      check($sformatf("row%0d_count", i), 64'(bus1.InstrCount), 64'(tbl[i].cnt));
      step();
    end

    // HALT is absorbing regardless of what the IR shows.
    bus1.Opcode = 6'h23;
    for (int i = 0; i < 20; i++) begin
      #4;
      check($sformatf("halt%0d_state", i), 64'(bus1.State), 64'd13);
      check($sformatf("halt%0d_ctl", i), 64'(ctl1), 64'(E_HALT));
      check($sformatf("halt%0d_count", i), 64'(bus1.InstrCount), 64'd9);
      step();
    end

    // lw with MEM_WAIT=2: three-cycle FETCH and MEM_READ.
    reset2 = 1'b1;
    for (int i = 0; i < 11; i++) begin
      #4;
      check($sformatf("lw2_%0d_state", i), 64'(bus2.State), 64'(exp2[i]));
      check($sformatf("lw2_%0d_iord", i), 64'(bus2.IorD), 64'(exp2[i] == 4'd4));
      check($sformatf("lw2_%0d_wb", i), 64'({bus2.RegWrite, bus2.MemToReg}),
            (exp2[i] == 4'd5) ? 64'd3 : 64'd0);
      step();
    end
    check("lw2_count", 64'(bus2.InstrCount), 64'd1);

    // MEM_WAIT=3: asynchronous reset in the second MEM_READ cycle.
    reset3 = 1'b1;
    for (int i = 0; i < 8; i++) step();
    check("rd3_state", 64'(bus3.State), 64'd4);
    check("rd3_iord", 64'(bus3.IorD), 64'd1);
    check("rd3_count", 64'(bus3.InstrCount), 64'd1);
    #1 reset3 = 1'b0;
    #1;
    check("rd3_async_state", 64'(bus3.State), 64'd0);
    check("rd3_async_iord", 64'(bus3.IorD), 64'd0);
    check("rd3_async_count", 64'(bus3.InstrCount), 64'd0);
    check("rd3_async_en", 64'({bus3.IRWrite, bus3.MemWrite, bus3.RegWrite, bus3.PCWrite}), 64'd0);
    step();
    reset3 = 1'b1;
    #4;
    check("rd3_rel_state", 64'(bus3.State), 64'd0);
    step();
    check("rd3_f0_state", 64'(bus3.State), 64'd1);
    check("rd3_f0_count", 64'(bus3.InstrCount), 64'd0);
    check("rd3_f0_irw", 64'(bus3.IRWrite), 64'd0);
    for (int i = 0; i < 3; i++) step();
    check("rd3_f3_state", 64'(bus3.State), 64'd1);
    check("rd3_f3_wr", 64'({bus3.IRWrite, bus3.PCWrite}), 64'd3);
    step();
    check("rd3_dec_state", 64'(bus3.State), 64'd2);
    check("rd3_dec_count", 64'(bus3.InstrCount), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
